// File: rtl/ps2_pkg.sv
// ps2_pkg: shared encodings, prefix/status constants and event layout for the PS/2 keyboard controller
package ps2_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} rx_state_e;
   localparam logic [7:0] PFX_EXT = 8'hE0;
   localparam logic [7:0] PFX_REL = 8'hF0;
   localparam int EVT_EXT = 9;
   localparam int EVT_REL = 8;
   localparam int EVT_W = 10;
   localparam logic [7:0][7:0] STATUS_BYTES = {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
   function automatic logic is_status(input logic [7:0] b);
      is_status = 1'b0;
      for (int i = 0; i < 8; i++) if (b == STATUS_BYTES[i]) is_status = 1'b1;
   endfunction
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises the PS/2 lines onto clk, frames 11-bit packets and flags bad or stalled frames
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 2500
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       frame_err_o
);
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
   logic                   clk_prev_q;
   rx_state_e              state_q;
   logic [2:0]             bit_cnt_q;
   logic [7:0]             shift_q;
   logic                   parity_q;
   logic [TW-1:0]          tmo_q;
   logic                   sync_clk, sync_data, fall, good;
   assign sync_clk  = clk_sync_q[SYNC_STAGES-1];
   assign sync_data = data_sync_q[SYNC_STAGES-1];
   assign fall      = clk_prev_q & ~sync_clk;
   assign good      = sync_data & (^{shift_q, parity_q});
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync_q   <= '1;
         data_sync_q  <= '1;
         clk_prev_q   <= 1'b1;
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         parity_q     <= 1'b0;
         tmo_q        <= '0;
         byte_o       <= '0;
         byte_valid_o <= 1'b0;
         frame_err_o  <= 1'b0;
      end else begin
         clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
         data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
         clk_prev_q   <= sync_clk;
         byte_valid_o <= 1'b0;
         frame_err_o  <= 1'b0;
         tmo_q        <= '0;
         if (fall) begin
            case (state_q)
               ST_IDLE: begin
                  if (sync_data) frame_err_o <= 1'b1;
                  else begin
                     state_q   <= ST_DATA;
                     bit_cnt_q <= '0;
                  end
               end
               ST_DATA: begin
                  shift_q   <= {sync_data, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
               end
               ST_PARITY: begin
                  parity_q <= sync_data;
                  state_q  <= ST_STOP;
               end
               ST_STOP: begin
                  state_q <= ST_IDLE;
                  if (good) begin
                     byte_o       <= shift_q;
                     byte_valid_o <= 1'b1;
                  end else frame_err_o <= 1'b1;
               end
               default: state_q <= ST_IDLE;
            endcase
         end else if (state_q != ST_IDLE) begin
            // a stalled frame is abandoned so the next start bit resynchronises
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
               state_q     <= ST_IDLE;
               frame_err_o <= 1'b1;
            end else tmo_q <= tmo_q + 1'b1;
         end
      end
   end
endmodule

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: PS/2 keyboard controller folding E0/F0 prefixes into single key events behind valid/ready
module ps2_kbd_ctrl
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 2500
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ps2_clk,
   input  logic             ps2_data,
   output logic [EVT_W-1:0] evt_data,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [7:0]       raw_data,
   output logic             raw_valid,
   output logic             frame_err,
   output logic             overflow
);
   logic [7:0] rx_byte;
   logic       rx_valid, rx_err, ext_q, rel_q, new_evt;
   ps2_frame_rx #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
      .clk         (clk),
      .reset       (reset),
      .ps2_clk_i   (ps2_clk),
      .ps2_data_i  (ps2_data),
      .byte_o      (rx_byte),
      .byte_valid_o(rx_valid),
      .frame_err_o (rx_err)
   );
   assign raw_data  = rx_byte;
   assign raw_valid = rx_valid;
   assign frame_err = rx_err;
   assign new_evt   = rx_valid && rx_byte != PFX_EXT && rx_byte != PFX_REL && !is_status(rx_byte);
   always_ff @(posedge clk) begin
      if (reset) begin
         ext_q     <= 1'b0;
         rel_q     <= 1'b0;
         evt_data  <= '0;
         evt_valid <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         overflow <= 1'b0;
         if (rx_err) {ext_q, rel_q} <= 2'b00;
         else if (rx_valid) begin
            if (rx_byte == PFX_EXT) ext_q <= 1'b1;
            else if (rx_byte == PFX_REL) rel_q <= 1'b1;
            else {ext_q, rel_q} <= 2'b00;
         end
         // an accept in the same cycle frees the slot, so the new event still loads
         if (new_evt && (!evt_valid || evt_ready)) begin
            evt_data[EVT_EXT]  <= ext_q;
            evt_data[EVT_REL]  <= rel_q;
            evt_data[7:0]      <= rx_byte;
            evt_valid          <= 1'b1;
         end else begin
            if (new_evt) overflow <= 1'b1;
            if (evt_ready) evt_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: directed PS/2 frames checked cycle-by-cycle against a packet-level model
module tb_ps2_kbd_ctrl;
   localparam int S = 2;
   localparam int T = 200;
   localparam int H = 20;
   logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, evt_ready = 1'b0;
   logic [9:0] evt_data;
   logic [7:0] raw_data;
   logic       evt_valid, raw_valid, frame_err, overflow;
   int checks = 0, errors = 0;
   int n_raw = 0, n_err = 0, n_ovf = 0, n_acc = 0;
   int b_raw, b_err, b_ovf, b_acc;
   logic [9:0] last_acc = '0;
   ps2_kbd_ctrl #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .evt_data(evt_data), .evt_valid(evt_valid), .evt_ready(evt_ready),
      .raw_data(raw_data), .raw_valid(raw_valid), .frame_err(frame_err), .overflow(overflow)
   );
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask
   // packet-level model: line delay, a bit queue per frame, and an event slot
   logic [S:0] mh_c = '1, mh_d = '1;
   int         bits[$];
   int         idle_n = 0;
   logic       m_ext = 0, m_rel = 0, m_evt_valid = 0, m_raw_valid = 0, m_err = 0, m_ovf = 0;
   logic [9:0] m_evt = '0;
   logic [7:0] m_raw = '0;
   always @(posedge clk) begin : model
      logic f, d, nv;
      logic [9:0] ev;
      logic [10:0] fr;
      if (reset) begin
         mh_c = '1; mh_d = '1; bits.delete(); idle_n = 0;
         m_ext = 0; m_rel = 0; m_evt_valid = 0; m_raw_valid = 0; m_err = 0; m_ovf = 0;
         m_evt = '0; m_raw = '0;
      end else begin
         f = mh_c[S] & ~mh_c[S-1];
         d = mh_d[S-1];
         nv = 0;
         ev = {m_ext, m_rel, m_raw};
         if (m_err) begin m_ext = 0; m_rel = 0; end
         else if (m_raw_valid) begin
            if (m_raw == 8'hE0) m_ext = 1;
            else if (m_raw == 8'hF0) m_rel = 1;
            else begin
               nv = !(m_raw inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF});
               m_ext = 0; m_rel = 0;
            end
         end
         m_ovf = 0;
         if (nv) begin
            if (!m_evt_valid || evt_ready) begin m_evt = ev; m_evt_valid = 1; end
            else m_ovf = 1;
         end else if (evt_ready) m_evt_valid = 0;
         m_raw_valid = 0; m_err = 0;
         if (f) begin
            bits.push_back(int'(d));
            idle_n = 0;
            if (bits.size() == 1 && d) begin m_err = 1; bits.delete(); end
            else if (bits.size() == 11) begin
               for (int i = 0; i < 11; i++) fr[i] = bits[i][0];
               if (fr[10] && (^fr[9:1])) begin m_raw = fr[8:1]; m_raw_valid = 1; end
               else m_err = 1;
               bits.delete();
            end
         end else if (bits.size() > 0) begin
            if (idle_n == T - 1) begin m_err = 1; bits.delete(); idle_n = 0; end
            else idle_n++;
         end
         mh_c = {mh_c[S-1:0], ps2_clk};
         mh_d = {mh_d[S-1:0], ps2_data};
      end
   end
   always @(negedge clk) begin
      chk("evt_valid", evt_valid, m_evt_valid);
      if (m_evt_valid) chk("evt_data", evt_data, m_evt);
      chk("raw_valid", raw_valid, m_raw_valid);
      chk("raw_data", raw_data, m_raw);
      chk("frame_err", frame_err, m_err);
      chk("overflow", overflow, m_ovf);
      if (raw_valid) n_raw++;
      if (frame_err) n_err++;
      if (overflow) n_ovf++;
      if (evt_valid && evt_ready) begin n_acc++; last_acc = evt_data; end
   end
   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask
   task automatic snap();
      b_raw = n_raw; b_err = n_err; b_ovf = n_ovf; b_acc = n_acc;
   endtask
   task automatic send(input logic [7:0] b, input logic bad = 1'b0, input int nf = 11);
      logic [10:0] fr;
      fr = {1'b1, (~^b) ^ bad, b, 1'b0};
      for (int i = 0; i < nf; i++) begin
         ps2_data = fr[i];
         tick(H);
         ps2_clk = 1'b0;
         tick(H);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      tick(H);
   endtask
   initial begin
      tick(3);
      chk("rst evt_valid", evt_valid, 0);
      chk("rst evt_data", evt_data, 0);
      chk("rst raw_valid", raw_valid, 0);
      chk("rst raw_data", raw_data, 0);
      chk("rst frame_err", frame_err, 0);
      chk("rst overflow", overflow, 0);
      reset = 1'b0;
      tick(2);
      snap(); send(8'h1C); tick(5);
      chk("t1 raw pulses", n_raw - b_raw, 1);
      chk("t1 raw_data", raw_data, 8'h1C);
      chk("t1 evt_valid", evt_valid, 1);
      chk("t1 evt_data", evt_data, 10'h01C);
      chk("t1 model evt", m_evt, 10'h01C);
      evt_ready = 1'b1; tick(2);
      chk("t1 evt cleared", evt_valid, 0);
      chk("t1 accepts", n_acc - b_acc, 1);
      snap(); send(8'hE0); send(8'hF0); send(8'h75); tick(5);
      chk("t2 raw pulses", n_raw - b_raw, 3);
      chk("t2 accepts", n_acc - b_acc, 1);
      chk("t2 evt_data", last_acc, 10'h375);
      chk("t2 model evt", m_evt, 10'h375);
      chk("t2 errors", n_err - b_err, 0);
      snap(); send(8'h1C, 1'b1); tick(5);
      chk("t3 errors", n_err - b_err, 1);
      chk("t3 accepts", n_acc - b_acc, 0);
      snap(); send(8'h1B); tick(5);
      chk("t3 accepts next", n_acc - b_acc, 1);
      chk("t3 evt_data", last_acc, 10'h01B);
      snap(); send(8'h1C, 1'b0, 5); tick(T + 50);
      chk("t4 timeout errors", n_err - b_err, 1);
      chk("t4 accepts", n_acc - b_acc, 0);
      snap(); send(8'h1C); tick(5);
      chk("t4 accepts next", n_acc - b_acc, 1);
      chk("t4 evt_data", last_acc, 10'h01C);
      evt_ready = 1'b0;
      snap(); send(8'h1C); send(8'h32); tick(5);
      chk("t5 evt_valid held", evt_valid, 1);
      chk("t5 evt_data held", evt_data, 10'h01C);
      chk("t5 overflow", n_ovf - b_ovf, 1);
      fork
         send(8'h21);
         begin
            int k = 0;
            while (!(raw_valid && raw_data == 8'h21) && k < 2000) begin tick(); k++; end
            chk("t5 raw 21 seen", k < 2000, 1);
            evt_ready = 1'b1;
         end
      join
      tick(5);
      chk("t5 overflow total", n_ovf - b_ovf, 1);
      chk("t5 accepts", n_acc - b_acc, 2);
      chk("t5 evt_data", last_acc, 10'h021);
      chk("t5 evt drained", evt_valid, 0);
      snap(); send(8'h1C, 1'b0, 5);
      reset = 1'b1; tick(2); reset = 1'b0;
      chk("t6 rst evt_valid", evt_valid, 0);
      tick(T + 50);
      chk("t6 errors", n_err - b_err, 0);
      chk("t6 accepts", n_acc - b_acc, 0);
      chk("t6 raw pulses", n_raw - b_raw, 0);
      send(8'hF0);
      reset = 1'b1; tick(2); reset = 1'b0; tick(2);
      snap(); send(8'h1C); tick(5);
      chk("t6 accepts", n_acc - b_acc, 1);
      chk("t6 evt_data", last_acc, 10'h01C);
      chk("t6 model evt", m_evt, 10'h01C);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
